// File: rtl/tx_lane_striper.sv
// TX byte striper: holds one input beat and emits it chunk by chunk, spreading bytes
// round-robin over the active lanes and packing them into 1/2/4-byte PIPE words.
module tx_lane_striper #(
  parameter int LANESNUMBER  = 16,
  parameter int MAXPIPEWIDTH = 32,
  parameter int IN_BYTES     = 64
) (
  input  logic                                pclk,
  input  logic                                reset_n,
  input  logic [4:0]                          cfg_lanes,
  input  logic [2:0]                          cfg_pipe_bytes,
  input  logic                                cfg_reverse,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [IN_BYTES*8-1:0]               in_data,
  input  logic [IN_BYTES-1:0]                 in_datak,
  output logic [LANESNUMBER*MAXPIPEWIDTH-1:0] tx_data,
  output logic [LANESNUMBER*MAXPIPEWIDTH/8-1:0] tx_datak,
  output logic [LANESNUMBER-1:0]              tx_datavalid,
  output logic                                busy
);

  localparam int MW  = MAXPIPEWIDTH / 8;
  localparam int IBW = $clog2(IN_BYTES);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                 state;
  logic [IBW-1:0]         cnt;
  logic [IN_BYTES*8-1:0]  hold_data;
  logic [IN_BYTES-1:0]    hold_k;
  logic [2:0]             n_log;
  logic [2:0]             w_log;
  logic                   rev_q;

  logic [2:0]             n_log_d;
  logic [2:0]             w_log_d;
  logic [IBW-1:0]         chunks_m1;
  logic [IBW-1:0]         n_val;
  logic [IBW-1:0]         w_val;
  logic                   last_chunk;
  logic                   accept;

  logic [LANESNUMBER*MAXPIPEWIDTH-1:0] emit_data;
  logic [LANESNUMBER*MW-1:0]           emit_k;
  logic [LANESNUMBER-1:0]              emit_valid;

  // Unsupported lane counts or PIPE widths fall back to x1 / 1 byte.
  always_comb begin
    n_log_d = 3'd0;
    case (cfg_lanes)
      5'd2:    n_log_d = 3'd1;
      5'd4:    n_log_d = 3'd2;
      5'd8:    n_log_d = 3'd3;
      5'd16:   n_log_d = 3'd4;
      default: n_log_d = 3'd0;
    endcase
    if ((1 << n_log_d) > LANESNUMBER) n_log_d = 3'd0;
    w_log_d = 3'd0;
    case (cfg_pipe_bytes)
      3'd2:    w_log_d = 3'd1;
      3'd4:    w_log_d = 3'd2;
      default: w_log_d = 3'd0;
    endcase
    if ((8 << w_log_d) > MAXPIPEWIDTH) w_log_d = 3'd0;
  end

  always_comb begin
    n_val      = IBW'(1) << n_log;
    w_val      = IBW'(1) << w_log;
    chunks_m1  = IBW'((IN_BYTES >> (int'(n_log) + int'(w_log))) - 1);
    last_chunk = (cnt == chunks_m1);
  end

  assign in_ready = reset_n & ((state == EMPTY) | last_chunk);
  assign accept   = in_valid & in_ready;

  // Physical lane p carries logical lane l; symbol j of chunk cnt is byte cnt*C + j*N + l.
  for (genvar p = 0; p < LANESNUMBER; p++) begin : g_lane
    logic [IBW-1:0] lidx;
    logic           lane_on;
    assign lane_on       = IBW'(p) < n_val;
    assign lidx          = rev_q ? (n_val - IBW'(p) - IBW'(1)) : IBW'(p);
    assign emit_valid[p] = lane_on;
    for (genvar j = 0; j < MW; j++) begin : g_sym
      logic           sym_on;
      logic [IBW-1:0] bidx;
      assign sym_on = lane_on & (IBW'(j) < w_val);
      assign bidx   = (cnt << (n_log + w_log)) + (IBW'(j) << n_log) + lidx;
      assign emit_data[p*MAXPIPEWIDTH+8*j +: 8] = sym_on ? hold_data[{bidx, 3'b000} +: 8] : 8'h00;
      assign emit_k[p*MW+j] = sym_on & hold_k[bidx];
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      state        <= EMPTY;
      cnt          <= '0;
      n_log        <= 3'd0;
      w_log        <= 3'd0;
      rev_q        <= 1'b0;
      tx_data      <= '0;
      tx_datak     <= '0;
      tx_datavalid <= '0;
      busy         <= 1'b0;
    end else begin
      if (state == FULL) begin
        tx_data      <= emit_data;
        tx_datak     <= emit_k;
        tx_datavalid <= emit_valid;
        cnt          <= last_chunk ? '0 : cnt + IBW'(1);
      end else begin
        tx_data      <= '0;
        tx_datak     <= '0;
        tx_datavalid <= '0;
      end
      if (accept) begin
        hold_data <= in_data;
        hold_k    <= in_datak;
        n_log     <= n_log_d;
        w_log     <= w_log_d;
        rev_q     <= cfg_reverse;
        cnt       <= '0;
        state     <= FULL;
        busy      <= 1'b1;
      end else if ((state == FULL) && last_chunk) begin
        state <= EMPTY;
        busy  <= 1'b0;
      end
    end
  end

endmodule
